// File: rtl/dport_ram.sv
// True dual-port synchronous RAM, one clock, registered read data per port.
// Optional macro DPORT_RAM_BYPASS_EN: a read that meets a write from the other port to the same address returns the new data.
module dport_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wenable1,
  input  logic              wenable2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout1, r_dout2;
  logic [DATA_W-1:0] w_rd1, w_rd2;

  always_comb begin
    w_rd1 = r_mem[addr1];
    w_rd2 = r_mem[addr2];
`ifdef DPORT_RAM_BYPASS_EN
    if (wenable2 && (addr2 == addr1)) w_rd1 = data_in2;
    if (wenable1 && (addr1 == addr2)) w_rd2 = data_in1;
`endif
  end

  // Port 2 is written first so port 1's assignment lands last and wins a same-address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_dout1 <= '0;
      r_dout2 <= '0;
    end else begin
      if (wenable2) r_mem[addr2] <= data_in2;
      else          r_dout2      <= w_rd2;
      if (wenable1) r_mem[addr1] <= data_in1;
      else          r_dout1      <= w_rd1;
    end
  end

  assign data_out1 = r_dout1;
  assign data_out2 = r_dout2;
endmodule

// File: tb/tb_dport_ram.sv
// Self-checking bench for dport_ram: directed scenarios then random traffic against an array model.
module tb_dport_ram;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset, wenable1, wenable2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [DATA_W-1:0] data_in1, data_in2, data_out1, data_out2;

  dport_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .wenable1(wenable1), .wenable2(wenable2),
    .addr1(addr1), .addr2(addr2),
    .data_in1(data_in1), .data_in2(data_in2),
    .data_out1(data_out1), .data_out2(data_out2)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_out1, m_out2;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, update model at posedge, compare both outputs just after.
  task automatic step(input string tag, input logic rst,
                      input logic we1, input int a1, input logic [DATA_W-1:0] d1,
                      input logic we2, input int a2, input logic [DATA_W-1:0] d2);
    logic [DATA_W-1:0] n1, n2;
    @(negedge clock);
    reset = rst; wenable1 = we1; wenable2 = we2;
    addr1 = a1[ADDR_W-1:0]; addr2 = a2[ADDR_W-1:0];
    data_in1 = d1; data_in2 = d2;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_out1 = '0; m_out2 = '0;
    end else begin
      n1 = m_out1; n2 = m_out2;
      if (!we1) n1 = m_mem[a1];
      if (!we2) n2 = m_mem[a2];
`ifdef DPORT_RAM_BYPASS_EN
      if (!we1 && we2 && a1 == a2) n1 = d2;
      if (!we2 && we1 && a1 == a2) n2 = d1;
`endif
      if (we2) m_mem[a2] = d2;
      if (we1) m_mem[a1] = d1;
      m_out1 = n1; m_out2 = n2;
    end
    #1;
    chk({tag, ".out1"}, data_out1, m_out1);
    chk({tag, ".out2"}, data_out2, m_out2);
  endtask

  initial begin
    reset = 1'b1; wenable1 = 1'b0; wenable2 = 1'b0;
    addr1 = '0; addr2 = '0; data_in1 = '0; data_in2 = '0;
    m_out1 = '0; m_out2 = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0);
    // Constants alongside the model pin the scenario values directly.
    step("rd_after_rst", 0, 0, 5, 0, 0, 2, 0);
    chk("rd_after_rst.abs", data_out1 | data_out2, 32'd0);
    step("wr_p2", 0, 0, 0, 0, 1, 7, 32'd88);
    step("wr_p1", 0, 1, 6, 32'd99, 0, 0, 0);
    step("rd_1_7", 0, 0, 1, 0, 0, 7, 0);
    chk("rd_7.abs", data_out2, 32'd88);
    step("wr_hold", 0, 1, 1, 32'h55, 0, 6, 0);
    chk("rd_6.abs", data_out2, 32'd99);
    step("rd_6", 0, 0, 6, 0, 1, 5, 32'h66);
    chk("rd_6p1.abs", data_out1, 32'd99);
    step("dual_wr", 0, 1, 0, 32'd13, 1, 4, 32'd96);
    step("rd_0_4", 0, 0, 0, 0, 0, 4, 0);
    chk("rd_0.abs", data_out1, 32'd13);
    chk("rd_4.abs", data_out2, 32'd96);
    step("collide", 0, 1, 3, 32'hA, 1, 3, 32'hB);
    step("rd_coll", 0, 0, 3, 0, 0, 3, 0);
    chk("coll.abs", data_out2, 32'hA);
    step("set2", 0, 1, 2, 32'd5, 0, 0, 0);
    step("xrw", 0, 1, 2, 32'd7, 0, 2, 0);
`ifdef DPORT_RAM_BYPASS_EN
    chk("xrw.abs", data_out2, 32'd7);
`else
    chk("xrw.abs", data_out2, 32'd5);
`endif
    step("xrw_after", 0, 0, 2, 0, 0, 2, 0);
    chk("xrw_after.abs", data_out1, 32'd7);
    step("xrw_p2w", 0, 0, 4, 0, 1, 4, 32'h1234);
    step("mid_rst", 1, 1, 0, 32'hFFFF, 1, 6, 32'hEEEE);
    chk("mid_rst.abs", data_out1 | data_out2, 32'd0);
    step("rd_0_4z", 0, 0, 0, 0, 0, 4, 0);
    step("rd_6_7z", 0, 0, 6, 0, 0, 7, 0);
    chk("rd_67z.abs", data_out1 | data_out2, 32'd0);

    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 49) == 0),
           $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom,
           $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom);
    end
    for (int k = 0; k < 200; k++) begin
      int a = $urandom_range(0, DEPTH-1);
      step("rand_same", 1'b0, $urandom_range(0, 1), a, $urandom,
           $urandom_range(0, 1), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
